// File: rtl/param_maze_fsm.sv
// Table-driven maze walker: debounced, edge-detected buttons step a token between rooms.
// Latency: BTN stable high first sampled at edge k -> STATE_OUT updates at edge k+2+DEBOUNCE_CYC.
// Backpressure: none; raw button levels in, registered room/goal/pulse/count out, no stalls.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset; every flop clears without a clock edge
//   BTN        raw asynchronous button levels, index 0 = LEFT, 1 = CENTRE, 2 = RIGHT
//   RESTART    synchronous return to START_STATE, clears MOVES, beats any press that cycle
//   STATE_OUT  current room (registered)
//   AT_GOAL    STATE_OUT == GOAL_STATE (registered alongside STATE_OUT)
//   MOVE_PULSE one-cycle strobe coincident with a room change
//   MOVES      saturating accepted-move count
//
// Build option: define MAZE_MOVE_COUNT_EN to implement the MOVE_W-bit move counter;
// when undefined there are no counter flops and MOVES is tied to zero.
module param_maze_fsm #(
  parameter int STATE_W      = 3,
  parameter int N_BTN        = 3,
  parameter int DEBOUNCE_CYC = 4,
  parameter int START_STATE  = 0,
  parameter int GOAL_STATE   = 7,
  parameter int LOCK_GOAL    = 1,
  parameter int MOVE_W       = 8,
  // entry(s,b) = TRANS_TABLE[(s*N_BTN+b)*STATE_W +: STATE_W]
  // listed from room 7 down to room 0, each room as {RIGHT, CENTRE, LEFT}
  parameter logic [(2**STATE_W)*N_BTN*STATE_W-1:0] TRANS_TABLE = {
    3'd7, 3'd7, 3'd7,   // s7
    3'd2, 3'd6, 3'd0,   // s6
    3'd0, 3'd3, 3'd5,   // s5
    3'd7, 3'd6, 3'd4,   // s4
    3'd2, 3'd3, 3'd4,   // s3
    3'd2, 3'd1, 3'd0,   // s2
    3'd2, 3'd1, 3'd5,   // s1
    3'd0, 3'd6, 3'd0    // s0
  }
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_BTN-1:0]   BTN,
  input  logic               RESTART,
  output logic [STATE_W-1:0] STATE_OUT,
  output logic               AT_GOAL,
  output logic               MOVE_PULSE,
  output logic [MOVE_W-1:0]  MOVES
);

  localparam int                 DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] GOAL_S  = STATE_W'(GOAL_STATE);

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchroniser, debounce, rising-edge detect
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] deb_q;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [N_BTN-1:0] press;

  // db_cnt counts consecutive synchronised samples that disagree with the
  // accepted level; any agreeing sample restarts it, so only an unbroken run
  // of DEBOUNCE_CYC disagreeing samples flips the accepted level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One event per accepted 0->1 of the debounced level; release is silent.
  assign press = deb & ~deb_q;

  // ---------------------------------------------------------------------------
  // Walker: next-room selection (combinational)
  // ---------------------------------------------------------------------------
  logic               sel_vld;
  int                 sel_idx;
  logic [STATE_W-1:0] nxt_room;
  logic               locked;
  logic               take_move;
  logic [STATE_W-1:0] room_d;
  logic               pulse_d;

  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = 0;
    nxt_room  = STATE_OUT;
    locked    = 1'b0;
    take_move = 1'b0;
    room_d    = STATE_OUT;
    pulse_d   = 1'b0;

    // Lowest-index press wins; other same-cycle presses are simply dropped.
    for (int b = 0; b < N_BTN; b++) begin
      if (press[b] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = b;
      end
    end

    nxt_room  = TRANS_TABLE[(int'(STATE_OUT) * N_BTN + sel_idx) * STATE_W +: STATE_W];
    locked    = (LOCK_GOAL != 0) && (STATE_OUT == GOAL_S);
    // A self-loop entry is not a move: no pulse, no count.
    take_move = sel_vld && !locked && (nxt_room != STATE_OUT);

    if (RESTART) begin
      room_d = START_S;
    end else if (take_move) begin
      room_d  = nxt_room;
      pulse_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Walker: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STATE_OUT  <= START_S;
      AT_GOAL    <= (START_S == GOAL_S);
      MOVE_PULSE <= 1'b0;
    end else begin
      STATE_OUT  <= room_d;
      AT_GOAL    <= (room_d == GOAL_S);
      MOVE_PULSE <= pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Move counter
  // ---------------------------------------------------------------------------
`ifdef MAZE_MOVE_COUNT_EN
  logic [MOVE_W-1:0] moves_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      moves_q <= '0;
    end else if (RESTART) begin
      moves_q <= '0;
    end else if (pulse_d && (moves_q != {MOVE_W{1'b1}})) begin
      moves_q <= moves_q + 1'b1;
    end
  end

  assign MOVES = moves_q;
`else
  assign MOVES = '0;
`endif

endmodule

// File: tb/tb_param_maze_fsm.sv
// Directed bench for param_maze_fsm at default parameters.
// Expected rooms, latencies and counts are hand-derived from the default map.
module tb_param_maze_fsm;

`ifdef MAZE_MOVE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] BTN;
  logic       RESTART;
  logic [2:0] STATE_OUT;
  logic       AT_GOAL;
  logic       MOVE_PULSE;
  logic [7:0] MOVES;

  bit clk_en = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int p0;

  param_maze_fsm dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BTN        (BTN),
    .RESTART    (RESTART),
    .STATE_OUT  (STATE_OUT),
    .AT_GOAL    (AT_GOAL),
    .MOVE_PULSE (MOVE_PULSE),
    .MOVES      (MOVES)
  );

  initial begin
    wait (clk_en);
    forever #5 CLK = ~CLK;
  end

  // Each pulse is high for exactly one full cycle, so one sample per negedge counts it once.
  always @(negedge CLK) begin
    if (MOVE_PULSE === 1'b1) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_mv(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int b);
    BTN = 3'(1 << b);
    hold(8);
    BTN = 3'b000;
    hold(8);
  endtask

  task automatic restart_pulse();
    RESTART = 1'b1;
    hold(1);
    RESTART = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq   [7] = '{1, 2, 1, 0, 1, 0, 2};
    int rooms [7] = '{6, 2, 1, 5, 3, 4, 7};

    // Reset with no clock running
    RESET   = 1'b1;
    BTN     = 3'b000;
    RESTART = 1'b0;
    #1;
    chk("rst_state", 32'(STATE_OUT), 0);
    chk("rst_goal", 32'(AT_GOAL), 0);
    chk("rst_pulse", 32'(MOVE_PULSE), 0);
    chk("rst_moves", 32'(MOVES), 0);
    #3 clk_en = 1'b1;
    hold(2);
    RESET = 1'b0;
    hold(2);

    // Single CENTRE press in room 0: first sampled at the next edge k, move at k+6
    p0  = pulse_cnt;
    BTN = 3'b010;
    hold(6);
    chk("press_not_early", 32'(STATE_OUT), 0);
    hold(1);
    chk("press_state", 32'(STATE_OUT), 6);
    chk("press_pulse_hi", 32'(MOVE_PULSE), 1);
    hold(1);
    chk("press_pulse_lo", 32'(MOVE_PULSE), 0);
    chk("press_moves", 32'(MOVES), exp_mv(1));
    hold(13);
    chk("held_state", 32'(STATE_OUT), 6);
    chk("held_pulses", 32'(pulse_cnt - p0), 1);
    BTN = 3'b000;
    hold(10);

    // Bounce on RIGHT in room 6: runs of 2 never reach the debounce threshold
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      BTN[2] = ~BTN[2];
      hold(2);
    end
    BTN = 3'b000;
    hold(12);
    chk("bounce_state", 32'(STATE_OUT), 6);
    chk("bounce_moves", 32'(MOVES), exp_mv(1));
    chk("bounce_pulses", 32'(pulse_cnt - p0), 0);

    // LEFT and RIGHT together in room 6: LEFT wins -> room 0
    p0  = pulse_cnt;
    BTN = 3'b101;
    hold(10);
    chk("simul_state", 32'(STATE_OUT), 0);
    chk("simul_moves", 32'(MOVES), exp_mv(2));
    chk("simul_pulses", 32'(pulse_cnt - p0), 1);
    BTN = 3'b000;
    hold(10);

    restart_pulse();
    chk("restart0_state", 32'(STATE_OUT), 0);
    chk("restart0_moves", 32'(MOVES), 0);

    // Walk C,R,C,L,C,L,R to the goal
    for (int i = 0; i < 7; i++) begin
      press(seq[i]);
      chk($sformatf("walk%0d_room", i), 32'(STATE_OUT), 32'(rooms[i]));
    end
    chk("walk_goal", 32'(AT_GOAL), 1);
    chk("walk_moves", 32'(MOVES), exp_mv(7));

    // Goal is locked: further presses change nothing
    p0 = pulse_cnt;
    press(0);
    press(1);
    chk("lock_state", 32'(STATE_OUT), 7);
    chk("lock_moves", 32'(MOVES), exp_mv(7));
    chk("lock_pulses", 32'(pulse_cnt - p0), 0);

    restart_pulse();
    chk("restart1_state", 32'(STATE_OUT), 0);
    chk("restart1_goal", 32'(AT_GOAL), 0);
    chk("restart1_moves", 32'(MOVES), 0);

    // Async reset mid-debounce of CENTRE, from room 2
    press(1);
    press(2);
    chk("pre_rst_state", 32'(STATE_OUT), 2);
    BTN = 3'b010;
    hold(3);
    #2 RESET = 1'b1;
    #1;
    chk("arst_state", 32'(STATE_OUT), 0);
    chk("arst_goal", 32'(AT_GOAL), 0);
    chk("arst_moves", 32'(MOVES), 0);
    @(negedge CLK);
    hold(2);
    RESET = 1'b0;
    p0    = pulse_cnt;
    hold(6);
    chk("rdeb_not_early", 32'(STATE_OUT), 0);
    hold(1);
    chk("rdeb_state", 32'(STATE_OUT), 6);
    chk("rdeb_pulse", 32'(MOVE_PULSE), 1);
    hold(10);
    chk("rdeb_held_state", 32'(STATE_OUT), 6);
    chk("rdeb_moves", 32'(MOVES), exp_mv(1));
    chk("rdeb_pulses", 32'(pulse_cnt - p0), 1);
    BTN = 3'b000;
    hold(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
